multiplexador_perifericos: RTL

MULTIPLEXADOR_PERIFERICOS -- requirements
Module: multiplexador_perifericos

---
 rtl/multiplexador_perifericos.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multiplexador_perifericos.sv
// ---------------------------------------------------------------------------
// multiplexador_perifericos
//
// Multiplexes CHANNELS peripheral read sources, plus one default source, onto
// a single registered output. A two-state FSM (IDLE/HOLD) handles the transfer:
//   IDLE : out follows 'other' each cycle. When any req is set, one channel
//          is picked and its data is captured into out. The FSM moves to HOLD.
//   HOLD : out/grant/valid stay frozen until the consumer asserts ready.
//          That completes the transfer, bumps count and returns to IDLE.
//
// Optional feature (macro ROUND_ROBIN_EN):
//   defined   - round-robin arbitration. A pointer sets the first index
//               searched and moves to just past the channel last served.
//   undefined - fixed priority. The lowest-index asserted req wins.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - asynchronous, active-high
//   req    - per-channel read requests (bit i = channel i)
//   data   - per-channel read data, channel i at [i*WIDTH +: WIDTH]
//   other  - default source shown while idle
//   ready  - consumer acceptance strobe (only meaningful in HOLD)
//   out    - registered selected data
//   valid  - out holds a granted channel's data
//   grant  - one-hot channel being served, or zero
//   count  - completed transfers, wraps at 16 bits
// ---------------------------------------------------------------------------
module multiplexador_perifericos #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [WIDTH-1:0]          other,
    input  logic                      ready,
    output logic [WIDTH-1:0]          out,
    output logic                      valid,
    output logic [CHANNELS-1:0]       grant,
    output logic [15:0]               count
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_reg;
    logic [WIDTH-1:0]    out_reg;
    logic                valid_reg;
    logic [CHANNELS-1:0] grant_reg;
    logic [15:0]         count_reg;

    // Unpack the flat data bus into per-channel words.
    logic [WIDTH-1:0] data_ch [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign data_ch[gi] = data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [IDX_W-1:0]    sel_idx;
    logic [CHANNELS-1:0] sel_onehot;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_reg;   // first index searched next time
    logic [IDX_W-1:0] cur_reg;      // channel held in HOLD

    // Walk req starting at the pointer, wrapping modulo CHANNELS.
    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(rr_ptr_reg) + k) % CHANNELS;
            if (!found && req[idx]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(idx);
            end
        end
    end
`else
    // Fixed priority: the lowest asserted index wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign sel_onehot = CHANNELS'(1) << sel_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            out_reg    <= '0;
            valid_reg  <= 1'b0;
            grant_reg  <= '0;
            count_reg  <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr_reg <= '0;
            cur_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg <= HOLD;
                        out_reg   <= data_ch[sel_idx];
                        grant_reg <= sel_onehot;
                        valid_reg <= 1'b1;
`ifdef ROUND_ROBIN_EN
                        cur_reg   <= sel_idx;
`endif
                    end else begin
                        out_reg   <= other;
                        grant_reg <= '0;
                        valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    // Everything stays frozen until the consumer accepts.
                    // New requests wait for the IDLE cycle that follows.
                    if (ready) begin
                        state_reg <= IDLE;
                        out_reg   <= other;
                        grant_reg <= '0;
                        valid_reg <= 1'b0;
                        count_reg <= count_reg + 16'd1;
`ifdef ROUND_ROBIN_EN
                        rr_ptr_reg <= (cur_reg == IDX_W'(CHANNELS - 1)) ? '0
                                                                        : cur_reg + 1'b1;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out   = out_reg;
    assign valid = valid_reg;
    assign grant = grant_reg;
    assign count = count_reg;

endmodule
